intr_arbiter_ctrl: RTL and testbench
====================================

Name: intr_arbiter_ctrl

Overview:
- Downstream consumer of the per-block interrupt combiners.
- Takes NUM_SRC sticky level interrupt lines and applies per-source masks.
- Arbitrates one source at a time and presents a registered irq/id pair to the CPU with an ack handshake.
- On ack, issues a one-cycle clear pulse back to the winning combiner, then confirms that the source line drops before it re-arms.

Parameters:
- NUM_SRC, 4, number of interrupt sources (2..16).
- ID_W, $clog2(NUM_SRC), width of the source id; derived, not overridden.
- CLR_WAIT_MAX, 15, max cycles in WAIT_DROP before flagging a clear failure (1..255).

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  reset, synchronous, active-low.
- src_intr_i  in  NUM_SRC  level interrupts from the combiners (registered at the source).
- src_mask_i  in  NUM_SRC  1 = source masked from arbitration.
- irq_o  out  1  registered interrupt to the CPU.
- irq_id_o  out  ID_W  id of the source being signalled; valid while irq_o=1.
- irq_ack_i  in  1  CPU acknowledge, single-cycle or level.
- src_clr_o  out  NUM_SRC  one-hot, one-cycle clear pulse to the serviced source.
- clr_err_o  out  1  sticky flag: the serviced source failed to drop within CLR_WAIT_MAX.
- clr_err_clr_i  in  1  clears clr_err_o.
- busy_o  out  1  1 whenever state != IDLE.

Behaviour:
- Reset (rst_n=0 sampled at clk):
  - state=IDLE.
  - irq_o=0, irq_id_o=0, src_clr_o=0, clr_err_o=0, busy_o=0.
  - Wait counter=0.
  - Reset mid-operation aborts any pending/active interrupt. No clear pulse is issued.
- All outputs are registered; no combinational path from any input to any output.
- FSM states: IDLE, ASSERT, WAIT_DROP.
- IDLE:
  - Compute req = src_intr_i & ~src_mask_i.
  - If req != 0: latch winner id (fixed priority, lowest index wins); irq_o<=1; irq_id_o<=id; state<=ASSERT.
  - Latency: request sampled at edge n gives irq_o=1 after edge n.
  - irq_ack_i is ignored in IDLE.
- ASSERT:
  - Hold irq_o=1 and irq_id_o stable until irq_ack_i=1 is sampled.
  - Masking or deasserting the source while in ASSERT does NOT withdraw irq_o; the interrupt is delivered once committed.
  - On ack: irq_o<=0; src_clr_o[id]<=1; cnt<=0; state<=WAIT_DROP.
- WAIT_DROP:
  - src_clr_o<=0 (pulse is exactly one cycle).
  - If src_intr_i[id]=0: state<=IDLE.
  - Else cnt<=cnt+1. If cnt+1==CLR_WAIT_MAX: clr_err_o<=1 and state<=IDLE. Re-arbitration may then pick the same source again.
  - Acks in WAIT_DROP are ignored.
- Other sources asserting during ASSERT/WAIT_DROP are held off. The combiners are sticky, so nothing is lost. They are arbitrated in the next IDLE cycle.
- Back-to-back: minimum spacing between successive irq_o assertions is 3 cycles (ack, drop check, IDLE arbitration).
- clr_err_o:
  - Set has priority over clr_err_clr_i in the same cycle.
  - Otherwise clr_err_clr_i=1 clears it next edge.
- busy_o<=1 on entering ASSERT; busy_o<=0 on entering IDLE.
- cnt is 8 bits and saturates. The counter cannot wrap because the exit check fires at CLR_WAIT_MAX.

Optional Feature:
- INTR_RR_PRIO_EN defined:
  - Round-robin arbitration.
  - A last-serviced id register (reset to NUM_SRC-1) sets priority: search starts at last+1, wrapping modulo NUM_SRC.
  - The register updates when a winner is latched.
- INTR_RR_PRIO_EN undefined: fixed priority, index 0 highest. No last-id register is instantiated.

Test Plan:
- Reset then src_intr_i=4'b0100, mask=0 -> irq_o=1, irq_id_o=2 one cycle after sampling. Ack -> src_clr_o=4'b0100 for exactly 1 cycle. Source drops next cycle -> IDLE, busy_o=0, clr_err_o=0.
- src_intr_i=4'b1010 simultaneous, fixed priority -> id=1 serviced first. After its clear and drop, id=3 is signalled with irq_o re-asserted 3 cycles after the ack.
- src_mask_i=4'b0001, src_intr_i=4'b0001 -> irq_o stays 0. Unmask -> irq_o=1, id=0. Mask again during ASSERT -> irq_o stays 1 until ack.
- Source held high after clear, CLR_WAIT_MAX=15 -> clr_err_o=1 after 15 WAIT_DROP cycles, state IDLE. clr_err_clr_i pulse -> clr_err_o=0. clr_err_clr_i in the same cycle as the set -> clr_err_o=1.
- rst_n=0 asserted while in ASSERT (id=2) -> next edge: irq_o=0, src_clr_o=0, busy_o=0. No clear pulse is ever issued for id 2.
- With INTR_RR_PRIO_EN, src_intr_i=4'b1111 continuously re-asserted -> service order 0,1,2,3,0. Without the macro -> 0 every time.

Source files
------------

// File: rtl/intr_arbiter_ctrl.sv
// intr_arbiter_ctrl: masks and arbitrates sticky level interrupts, presents a
// registered irq/id pair to the CPU, pulses a one-hot clear to the serviced
// source on ack, then waits for that source line to drop before re-arming.
// Optional build macro: INTR_RR_PRIO_EN selects round-robin arbitration
// (default build: fixed priority, index 0 highest).
module intr_arbiter_ctrl #(
    parameter  int NUM_SRC      = 4,
    parameter  int CLR_WAIT_MAX = 15,
    localparam int ID_W         = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] src_intr_i,
    input  logic [NUM_SRC-1:0] src_mask_i,
    output logic               irq_o,
    output logic [ID_W-1:0]    irq_id_o,
    input  logic               irq_ack_i,
    output logic [NUM_SRC-1:0] src_clr_o,
    output logic               clr_err_o,
    input  logic               clr_err_clr_i,
    output logic               busy_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ASSERT    = 2'd1,
        WAIT_DROP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               irq_q, irq_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [NUM_SRC-1:0] clr_q, clr_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [7:0]         cnt_inc;
    logic               err_set;
    logic [NUM_SRC-1:0] req;
    logic               found;
    logic [ID_W-1:0]    win_id;
`ifdef INTR_RR_PRIO_EN
    logic [ID_W-1:0]    last_q, last_d;
`endif

    // Winner selection over the unmasked requests.
    always_comb begin
        req    = src_intr_i & ~src_mask_i;
        found  = 1'b0;
        win_id = '0;
`ifdef INTR_RR_PRIO_EN
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            int unsigned idx;
            idx = (int'(last_q) + 1 + i) % NUM_SRC;
            if (!found && req[idx]) begin
                found  = 1'b1;
                win_id = ID_W'(idx);
            end
        end
`else
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (!found && req[i]) begin
                found  = 1'b1;
                win_id = ID_W'(i);
            end
        end
`endif
    end

    // Next-state and registered-output computation for the service FSM.
    always_comb begin
        state_d = state_q;
        irq_d   = irq_q;
        id_d    = id_q;
        clr_d   = '0;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        err_set = 1'b0;
        cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
`ifdef INTR_RR_PRIO_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    irq_d   = 1'b1;
                    id_d    = win_id;
                    busy_d  = 1'b1;
                    state_d = ASSERT;
`ifdef INTR_RR_PRIO_EN
                    last_d  = win_id;
`endif
                end
            end
            ASSERT: begin
                if (irq_ack_i) begin
                    irq_d       = 1'b0;
                    clr_d[id_q] = 1'b1;
                    cnt_d       = '0;
                    state_d     = WAIT_DROP;
                end
            end
            WAIT_DROP: begin
                if (!src_intr_i[id_q]) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == 8'(CLR_WAIT_MAX)) begin
                        err_set = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
        // A new failure outranks a software clear in the same cycle.
        if (err_set) begin
            err_d = 1'b1;
        end else if (clr_err_clr_i) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
            id_q    <= '0;
            clr_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef INTR_RR_PRIO_EN
            last_q  <= ID_W'(NUM_SRC - 1);
`endif
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
            id_q    <= id_d;
            clr_q   <= clr_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
`ifdef INTR_RR_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    assign irq_o     = irq_q;
    assign irq_id_o  = id_q;
    assign src_clr_o = clr_q;
    assign clr_err_o = err_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_intr_arbiter_ctrl.sv
// Testbench for intr_arbiter_ctrl: directed scenarios followed by randomized
// traffic from emulated sticky combiners, checked against a behavioural model.
module tb_intr_arbiter_ctrl;

    localparam int N    = 4;
    localparam int MAXW = 15;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] src_intr;
    logic [N-1:0] src_mask;
    logic         irq;
    logic [1:0]   irq_id;
    logic         ack;
    logic [N-1:0] src_clr;
    logic         clr_err;
    logic         err_clr;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: phase 0 = nothing pending, 1 = interrupt delivered,
    // 2 = waiting for the serviced line to fall.
    int           ph;
    logic         m_irq;
    int           m_id;
    logic [N-1:0] m_clr;
    logic         m_err;
    logic         m_busy;
    int           m_cnt;
    int           m_last;

    always #5 clk = ~clk;

    intr_arbiter_ctrl #(.NUM_SRC(N), .CLR_WAIT_MAX(MAXW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src_intr_i   (src_intr),
        .src_mask_i   (src_mask),
        .irq_o        (irq),
        .irq_id_o     (irq_id),
        .irq_ack_i    (ack),
        .src_clr_o    (src_clr),
        .clr_err_o    (clr_err),
        .clr_err_clr_i(err_clr),
        .busy_o       (busy)
    );

    function automatic int pick(logic [N-1:0] req, int last);
`ifdef INTR_RR_PRIO_EN
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return 0;
`else
        logic [N-1:0] low;
        low = req & (~req + 1'b1);
        return $clog2(low);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_edge();
        logic         eset;
        logic [N-1:0] req;
        eset = 1'b0;
        if (!rst_n) begin
            ph = 0; m_irq = 0; m_id = 0; m_clr = '0; m_err = 0; m_busy = 0;
            m_cnt = 0; m_last = N - 1;
            return;
        end
        m_clr = '0;
        if (ph == 0) begin
            req = src_intr & ~src_mask;
            if (req != 0) begin
                m_id = pick(req, m_last); m_last = m_id;
                m_irq = 1; m_busy = 1; ph = 1;
            end
        end else if (ph == 1) begin
            if (ack) begin
                m_irq = 0; m_clr[m_id] = 1'b1; m_cnt = 0; ph = 2;
            end
        end else begin
            if (!src_intr[m_id]) begin
                ph = 0; m_busy = 0;
            end else begin
                m_cnt++;
                if (m_cnt == MAXW) begin
                    eset = 1; ph = 0; m_busy = 0;
                end
            end
        end
        if (eset) m_err = 1;
        else if (err_clr) m_err = 0;
    endtask

    // One clock: advance the model at the edge, compare outputs 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("irq", 32'(irq), 32'(m_irq));
        if (m_irq) check("irq_id", 32'(irq_id), 32'(m_id));
        check("src_clr", 32'(src_clr), 32'(m_clr));
        check("clr_err", 32'(clr_err), 32'(m_err));
        check("busy", 32'(busy), 32'(m_busy));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int           served;
        int           exp_ids[5];
        logic [N-1:0] stuck;
        logic         prev_irq;

        rst_n = 0; src_intr = '0; src_mask = '0; ack = 0; err_clr = 0;
        steps(2);
        check("reset_id", 32'(irq_id), 32'd0);
        rst_n = 1;

        // Single source 2: deliver, ack, one-cycle clear, drop.
        src_intr = 4'b0100; step();
        check("s2_id", 32'(irq_id), 32'd2);
        ack = 1; step();
        check("s2_clr", 32'(src_clr), 32'b0100);
        ack = 0; src_intr = '0; step();
        check("s2_busy", 32'(busy), 32'd0);
        step();

        // Two simultaneous sources: 1 first, then 3.
        src_intr = 4'b1010; step();
        ack = 1; step();
        ack = 0; src_intr = 4'b1000; steps(2);
        check("b2b_id", 32'(irq_id), 32'd3);
        ack = 1; step();
        ack = 0; src_intr = '0; steps(2);

        // Masking before and during delivery.
        src_mask = 4'b0001; src_intr = 4'b0001; steps(3);
        src_mask = '0; step();
        src_mask = 4'b0001; steps(2);
        check("mask_hold", 32'(irq), 32'd1);
        ack = 1; step();
        ack = 0; src_intr = '0; src_mask = '0; steps(2);

        // Source stuck high: error after MAXW waiting cycles, then clear.
        src_intr = 4'b0001; step();
        ack = 1; step(); ack = 0;
        steps(MAXW);
        check("err_set", 32'(clr_err), 32'd1);
        src_intr = '0; err_clr = 1; step();
        err_clr = 0; step();
        check("err_cleared", 32'(clr_err), 32'd0);
        ack = 1; step(); ack = 0; steps(2);
        // Same case with the clear held through the setting cycle.
        src_intr = 4'b0001; step();
        ack = 1; step(); ack = 0;
        err_clr = 1; steps(MAXW);
        check("err_set_wins", 32'(clr_err), 32'd1);
        err_clr = 0; src_intr = '0; step();
        ack = 1; step(); ack = 0; steps(2);

        // Reset while delivering id 2: no clear pulse ever follows.
        src_intr = 4'b0100; steps(2);
        rst_n = 0; step();
        check("rst_irq", 32'(irq), 32'd0);
        rst_n = 1; src_intr = '0; ack = 1; steps(3);
        ack = 0; steps(2);

        // All sources re-asserting continuously: service order.
`ifdef INTR_RR_PRIO_EN
        exp_ids = '{0, 1, 2, 3, 0};
`else
        exp_ids = '{0, 0, 0, 0, 0};
`endif
        served = 0; prev_irq = 0;
        for (int c = 0; c < 60 && served < 5; c++) begin
            src_intr = 4'b1111 & ~src_clr;
            ack = irq;
            step();
            if (irq && !prev_irq) begin
                check("order", 32'(irq_id), 32'(exp_ids[served]));
                served++;
            end
            prev_irq = irq;
        end
        check("order_count", 32'(served), 32'd5);
        ack = 0; src_intr = '0; steps(4);

        // Randomized traffic from emulated sticky combiners.
        stuck = '0;
        for (int c = 0; c < 2000; c++) begin
            if (c % 200 == 0) stuck = ($urandom_range(0, 3) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
            src_intr = (src_intr & ~(src_clr & ~stuck)) |
                       (($urandom_range(0, 3) == 0) ? N'($urandom) : '0);
            if ($urandom_range(0, 19) == 0) src_mask = N'($urandom) & N'($urandom);
            ack     = ($urandom_range(0, 2) == 0);
            err_clr = ($urandom_range(0, 15) == 0);
            rst_n   = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
